// File: rtl/tdm_pkg.sv
// Shared types and elaboration helpers for the TDM receive demultiplexer.
// Slot counts outside MIN..MAX are rejected when the top is elaborated.
package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_e;

    localparam int TDM_MIN_CHANNELS = 2;
    localparam int TDM_MAX_CHANNELS = 16;

    // Slot index width; a 2-slot frame still needs one bit.
    function automatic int tdm_idx_w(input int ch);
        return (ch < 2) ? 1 : $clog2(ch);
    endfunction

    function automatic bit tdm_chan_legal(input int ch);
        return (ch >= TDM_MIN_CHANNELS) && (ch <= TDM_MAX_CHANNELS);
    endfunction

endpackage

// File: rtl/tdm_frame_collector.sv
// Slot tracking FSM and shadow buffer. frame_done/frame_data are combinational
// from the final beat so the top can register the frame on that same edge.
module tdm_frame_collector
    import tdm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_valid,
    input  logic                             in_sync,
    output logic                             frame_done,
    output logic [CHANNELS-1:0][WIDTH-1:0]   frame_data,
    output logic                             frame_err
);

    localparam int IW = tdm_idx_w(CHANNELS);
    typedef logic [IW-1:0] idx_t;
    localparam idx_t LAST = idx_t'(CHANNELS - 1);

    tdm_state_e                     state;
    idx_t                           idx;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow;

    always_comb begin
        frame_done = in_valid && !in_sync && (state == COLLECT) && (idx == LAST);
        frame_data = shadow;
        frame_data[CHANNELS-1] = in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            idx       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (in_valid) begin
                if (in_sync) begin
                    // A sync mid-frame restarts collection from this beat.
                    shadow[0] <= in_data;
                    idx       <= idx_t'(1);
                    state     <= COLLECT;
                    frame_err <= (state == COLLECT);
                end else if (state == COLLECT) begin
                    shadow[idx] <= in_data;
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= HUNT;
                    end else begin
                        idx <= idx + idx_t'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: serial slot stream in, one frame of parallel
// lanes out through a valid/ready register with sticky overrun reporting.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    input  logic                        in_sync,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        frame_err,
    output logic                        overrun
);

    if (!tdm_chan_legal(CHANNELS)) begin : g_bad_channels
        $error("tdm_demux: CHANNELS must be in 2..16");
    end

    logic                           frame_done;
    logic [CHANNELS-1:0][WIDTH-1:0] frame_data;
    logic [CHANNELS-1:0][WIDTH-1:0] out_q;

    tdm_frame_collector #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_collector (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .frame_done (frame_done),
        .frame_data (frame_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (frame_done) begin
            // A new frame always wins; it is only lost data if the old one was unconsumed.
            out_q     <= frame_data;
            out_valid <= 1'b1;
            if (out_valid && !out_ready)
                overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed vector bench for tdm_demux (WIDTH=8, CHANNELS=4).
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sync;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic        is;
        logic [7:0]  d;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic r, input logic iv, input logic is, input logic [7:0] d,
                       input logic rdy, input logic ev, input logic [31:0] ed,
                       input logic ee, input logic eo);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.is = is; v.d = d; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ee = ee; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic is,
                         input logic [7:0] d, input logic rdy);
        rst_n = r; in_valid = iv; in_sync = is; in_data = d; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] ed,
                           input logic ee, input logic eo);
        chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ev});
        chk({tag, " out_data"},  out_data, ed);
        chk({tag, " frame_err"}, {31'b0, frame_err}, {31'b0, ee});
        chk({tag, " overrun"},   {31'b0, overrun}, {31'b0, eo});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset
        row(0,0,0,8'h00,0, 0,32'h0,0,0);
        row(0,0,0,8'h00,0, 0,32'h0,0,0);
        // basic frame
        row(1,1,1,8'h11,1, 0,32'h0,0,0);
        row(1,1,0,8'h22,1, 0,32'h0,0,0);
        row(1,1,0,8'h33,1, 0,32'h0,0,0);
        row(1,1,0,8'h44,1, 1,32'h44332211,0,0);
        row(1,0,0,8'h00,1, 0,32'h44332211,0,0);
        // hunt drops unsynced beats, gaps do not advance idx
        row(1,1,0,8'hAA,1, 0,32'h44332211,0,0);
        row(1,1,0,8'hBB,1, 0,32'h44332211,0,0);
        row(1,1,1,8'h01,1, 0,32'h44332211,0,0);
        row(1,0,0,8'h00,1, 0,32'h44332211,0,0);
        row(1,1,0,8'h02,1, 0,32'h44332211,0,0);
        row(1,0,0,8'h00,1, 0,32'h44332211,0,0);
        row(1,0,1,8'hEE,1, 0,32'h44332211,0,0);
        row(1,1,0,8'h03,1, 0,32'h44332211,0,0);
        row(1,1,0,8'h04,1, 1,32'h04030201,0,0);
        row(1,0,0,8'h00,1, 0,32'h04030201,0,0);
        // premature sync
        row(1,1,1,8'h10,1, 0,32'h04030201,0,0);
        row(1,1,0,8'h20,1, 0,32'h04030201,0,0);
        row(1,1,1,8'h30,1, 0,32'h04030201,1,0);
        row(1,1,0,8'h40,1, 0,32'h04030201,0,0);
        row(1,1,0,8'h50,1, 0,32'h04030201,0,0);
        row(1,1,0,8'h60,1, 1,32'h60504030,0,0);
        row(1,0,0,8'h00,1, 0,32'h60504030,0,0);
        // held frame, then completion coinciding with consume
        row(1,1,1,8'hC1,0, 0,32'h60504030,0,0);
        row(1,1,0,8'hC2,0, 0,32'h60504030,0,0);
        row(1,1,0,8'hC3,0, 0,32'h60504030,0,0);
        row(1,1,0,8'hC4,0, 1,32'hC4C3C2C1,0,0);
        row(1,1,1,8'hD1,0, 1,32'hC4C3C2C1,0,0);
        row(1,1,0,8'hD2,0, 1,32'hC4C3C2C1,0,0);
        row(1,1,0,8'hD3,0, 1,32'hC4C3C2C1,0,0);
        row(1,1,0,8'hD4,1, 1,32'hD4D3D2D1,0,0);
        row(1,0,0,8'h00,1, 0,32'hD4D3D2D1,0,0);
        // backpressure: back-to-back A then B without consume
        row(1,1,1,8'hA1,0, 0,32'hD4D3D2D1,0,0);
        row(1,1,0,8'hA2,0, 0,32'hD4D3D2D1,0,0);
        row(1,1,0,8'hA3,0, 0,32'hD4D3D2D1,0,0);
        row(1,1,0,8'hA4,0, 1,32'hA4A3A2A1,0,0);
        row(1,1,1,8'hB1,0, 1,32'hA4A3A2A1,0,0);
        row(1,1,0,8'hB2,0, 1,32'hA4A3A2A1,0,0);
        row(1,1,0,8'hB3,0, 1,32'hA4A3A2A1,0,0);
        row(1,1,0,8'hB4,0, 1,32'hB4B3B2B1,0,1);
        row(1,0,0,8'h00,0, 1,32'hB4B3B2B1,0,1);
        row(1,0,0,8'h00,1, 0,32'hB4B3B2B1,0,1);
        row(1,0,0,8'h00,0, 0,32'hB4B3B2B1,0,1);
        // reset mid-frame
        row(1,1,1,8'h55,0, 0,32'hB4B3B2B1,0,1);
        row(1,1,0,8'h66,0, 0,32'hB4B3B2B1,0,1);
        row(0,0,0,8'h00,0, 0,32'h0,0,0);
        row(1,1,0,8'h77,0, 0,32'h0,0,0);
        row(1,1,0,8'h78,0, 0,32'h0,0,0);
        row(1,1,1,8'h81,0, 0,32'h0,0,0);
        row(1,1,0,8'h82,0, 0,32'h0,0,0);
        row(1,1,0,8'h83,0, 0,32'h0,0,0);
        row(1,1,0,8'h84,0, 1,32'h84838281,0,0);
        row(1,0,0,8'h00,1, 0,32'h84838281,0,0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst_n, vecs[i].iv, vecs[i].is, vecs[i].d, vecs[i].rdy);
            chk_all(tag, vecs[i].ev, vecs[i].ed, vecs[i].ee, vecs[i].eo);
        end

        // frame_err lasts one cycle even when the stream then idles
        drive(1,1,1,8'h91,0);
        drive(1,1,0,8'h92,0);
        drive(1,1,1,8'h93,0);
        chk("seq err pulse", {31'b0, frame_err}, 32'd1);
        drive(1,0,0,8'h00,0);
        chk("seq err clears", {31'b0, frame_err}, 32'd0);
        drive(1,1,0,8'h94,0);
        drive(1,1,0,8'h95,0);
        chk("seq no early valid", {31'b0, out_valid}, 32'd0);
        drive(1,1,0,8'h96,0);
        chk("seq restart valid", {31'b0, out_valid}, 32'd1);
        chk("seq restart data", out_data, 32'h96959493);

        // two-slot-premature at frame boundary: sync right after completion is not an error
        drive(1,1,1,8'h01,1);
        chk("seq boundary sync no err", {31'b0, frame_err}, 32'd0);
        chk("seq boundary consume", {31'b0, out_valid}, 32'd0);
        chk("seq boundary overrun", {31'b0, overrun}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
